// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with chain accumulator and
// saturating count of completed legal operations.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             el,
   input  logic             chain,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity,
   output logic             err,
   output logic [CNT_W-1:0] op_count,
   input  logic             clr_cnt
);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       op;
      logic             el;
      logic             chain;
   } s1_t;

   s1_t              s1_q;
   logic             s1_valid;
   logic             s2_adv;
   logic             fire;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] res_c;
   logic [WIDTH-1:0] res_f;
   logic             op_ok;
   logic             legal;

   logic is_and, is_or, is_not;
   logic is_nand, is_nor, is_xor;

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;
   assign fire     = s1_valid && s2_adv;

   // chained ops read the value written by the previous compute
   assign opa = s1_q.chain ? acc : s1_q.a;

   assign is_and  = (s1_q.op == 3'b101);
   assign is_or   = (s1_q.op == 3'b110);
   assign is_not  = (s1_q.op == 3'b111);
   assign is_nand = (s1_q.op == 3'b000);
   assign is_nor  = (s1_q.op == 3'b001);
   assign is_xor  = (s1_q.op == 3'b010);

   always_comb begin
      res_c = '0;
      op_ok = 1'b1;
      unique case (1'b1)
         is_and:  res_c = opa & s1_q.b;
         is_or:   res_c = opa | s1_q.b;
         is_not:  res_c = ~opa;
         is_nand: res_c = ~(opa & s1_q.b);
         is_nor:  res_c = ~(opa | s1_q.b);
         is_xor:  res_c = opa ^ s1_q.b;
         default: op_ok = 1'b0;
      endcase
   end

   assign legal = op_ok && !s1_q.el;
   assign res_f = legal ? res_c : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_q <= '{a: a, b: b, op: op,
                      el: el, chain: chain};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         parity    <= 1'b0;
         err       <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result <= res_f;
            zero   <= ~|res_f;
            parity <= ^res_f;
            err    <= !legal;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (fire && legal) begin
         acc <= res_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (clr_cnt) begin
         op_count <= '0;
      end else if (fire && legal && (op_count != '1)) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: queue model plus directed vectors,
// second instance with a 2-bit counter for saturation and clear.
module tb_logic_unit_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  a, b, result;
   logic [2:0]  op;
   logic        el, chain, zero, parity, err, clr_cnt;
   logic [15:0] op_count;

   logic        in_valid1, in_ready1, out_valid1, out_ready1;
   logic [7:0]  a1, b1, result1;
   logic [2:0]  op1;
   logic        el1, chain1, zero1, parity1, err1, clr_cnt1;
   logic [1:0]  op_count1;

   int vectors = 0;
   int miscompares = 0;
   int pushes = 0;

   typedef struct {
      logic [7:0]  res;
      logic        err;
      logic        zero;
      logic        parity;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      bit         chk;
      logic [7:0] v;
   } lit_t;

   exp_t       mq[$];
   lit_t       lq[$];
   logic [7:0]  macc;
   logic [15:0] mcnt;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .el(el), .chain(chain),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .parity(parity),
      .err(err), .op_count(op_count), .clr_cnt(clr_cnt)
   );

   logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .op(op1), .el(el1), .chain(chain1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .result(result1), .zero(zero1), .parity(parity1),
      .err(err1), .op_count(op_count1), .clr_cnt(clr_cnt1)
   );

   task automatic check(input string nm,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // reference: evaluate each accepted transaction in issue order
   initial begin
      macc = '0;
      mcnt = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            lq.delete();
            macc = '0;
            mcnt = '0;
         end else begin
            if (out_valid && out_ready && mq.size() > 0) begin
               void'(mq.pop_front());
               if (lq.size() > 0) void'(lq.pop_front());
            end
            if (in_valid && in_ready) begin
               logic [7:0] x;
               logic [7:0] r;
               bit ok;
               exp_t e;
               x = chain ? macc : a;
               ok = !el;
               r = 8'h00;
               case (op)
                  3'b101: r = x & b;
                  3'b110: r = x | b;
                  3'b111: r = ~x;
                  3'b000: r = ~(x & b);
                  3'b001: r = ~(x | b);
                  3'b010: r = x ^ b;
                  default: ok = 1'b0;
               endcase
               if (!ok) r = 8'h00;
               if (ok) begin
                  macc = r;
                  if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
               end
               e.res = r;
               e.err = !ok;
               e.zero = (r == 8'h00);
               e.parity = ^r;
               e.cnt = mcnt;
               mq.push_back(e);
               pushes++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            vectors++;
            if (mq.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_out: got result=%h, expected no output",
                        result);
            end else begin
               exp_t e;
               e = mq[0];
               if ({result, err, zero, parity, op_count} !==
                   {e.res, e.err, e.zero, e.parity, e.cnt}) begin
                  miscompares++;
                  $display("FAIL out: got r=%h e=%b z=%b p=%b c=%0d expected r=%h e=%b z=%b p=%b c=%0d",
                           result, err, zero, parity, op_count,
                           e.res, e.err, e.zero, e.parity, e.cnt);
               end
               if (lq.size() > 0 && lq[0].chk) begin
                  check("literal_result", {24'h0, result}, {24'h0, lq[0].v});
               end
            end
         end
      end
   end

   task automatic note(input bit c, input logic [7:0] ev);
      lit_t l;
      l.chk = c;
      l.v = ev;
      lq.push_back(l);
   endtask

   task automatic send(input logic [7:0] ta, input logic [7:0] tb_,
                       input logic [2:0] top, input logic tel,
                       input logic tch, input bit c,
                       input logic [7:0] ev);
      bit ok;
      int n;
      n = 0;
      a = ta; b = tb_; op = top; el = tel; chain = tch;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 100);
      in_valid = 1'b0;
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      else note(c, ev);
   endtask

   task automatic send1(input logic [7:0] ta, input logic [2:0] top);
      bit ok;
      int n;
      n = 0;
      a1 = ta; b1 = 8'h0F; op1 = top; el1 = 1'b0; chain1 = 1'b0;
      in_valid1 = 1'b1;
      do begin
         @(negedge clk);
         ok = in_ready1;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 100);
      in_valid1 = 1'b0;
      if (!ok) check("send1_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((mq.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_done", {31'd0, (n < 100)}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   logic [7:0] sa[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [2:0] so[4] = '{3'b110, 3'b101, 3'b010, 3'b001};
   logic [7:0] se[4] = '{8'h1F, 8'h02, 8'h3C, 8'hB0};

   initial begin
      int p0;
      int k;
      bit ok;
      rst_n = 1'b0;
      in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0;
      el = 0; chain = 0; clr_cnt = 0;
      in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; op1 = 0;
      el1 = 0; chain1 = 0; clr_cnt1 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", {24'd0, result}, 32'd0);
      check("rst_flags", {29'd0, zero, parity, err}, 32'd0);
      check("rst_op_count", {16'd0, op_count}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      out_ready1 = 1'b1;

      send(8'hF0, 8'h3C, 3'b101, 0, 0, 1, 8'h30);
      drain();
      check("cnt_after_and", {16'd0, op_count}, 32'd1);

      send(8'hA5, 8'h0F, 3'b101, 0, 0, 1, 8'h05);
      send(8'hA5, 8'h0F, 3'b110, 0, 0, 1, 8'hAF);
      send(8'hA5, 8'h0F, 3'b111, 0, 0, 1, 8'h5A);
      send(8'hA5, 8'h0F, 3'b000, 0, 0, 1, 8'hFA);
      send(8'hA5, 8'h0F, 3'b001, 0, 0, 1, 8'h50);
      send(8'hA5, 8'h0F, 3'b010, 0, 0, 1, 8'hAA);
      drain();
      check("cnt_after_stream", {16'd0, op_count}, 32'd7);

      send(8'h12, 8'h34, 3'b011, 0, 0, 1, 8'h00);
      send(8'h12, 8'h34, 3'b110, 1, 0, 1, 8'h00);
      drain();
      check("cnt_after_illegal", {16'd0, op_count}, 32'd7);
      send(8'h00, 8'h00, 3'b110, 0, 1, 1, 8'hAA);
      drain();

      send(8'hFF, 8'h0F, 3'b010, 0, 0, 1, 8'hF0);
      send(8'h00, 8'h3C, 3'b101, 0, 1, 1, 8'h30);
      send(8'h00, 8'h00, 3'b111, 0, 1, 1, 8'hCF);
      drain();

      out_ready = 1'b0;
      p0 = pushes;
      k = 0;
      for (int c = 0; c < 5; c++) begin
         a = sa[k]; b = 8'h0F; op = so[k]; el = 0; chain = 0;
         in_valid = 1'b1;
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) begin
            note(1, se[k]);
            k++;
         end
      end
      in_valid = 1'b0;
      check("stall_accepted", pushes - p0, 32'd2);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_held", {24'd0, result}, 32'h1F);
      out_ready = 1'b1;
      while (k < 4) begin
         send(sa[k], 8'h0F, so[k], 0, 0, 1, se[k]);
         k++;
      end
      drain();
      check("stall_total", pushes - p0, 32'd4);

      send(8'h0F, 8'hF0, 3'b110, 0, 0, 1, 8'hFF);
      send(8'h0F, 8'hF0, 3'b010, 0, 0, 1, 8'hFF);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_result", {24'd0, result}, 32'd0);
      check("arst_flags", {29'd0, zero, parity, err}, 32'd0);
      check("arst_op_count", {16'd0, op_count}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         check("no_stale_valid", {31'd0, out_valid}, 32'd0);
      end
      send(8'h00, 8'h00, 3'b110, 0, 1, 1, 8'h00);
      drain();
      check("acc_cleared_zero", {31'd0, zero}, 32'd1);
      check("cnt_after_rst_op", {16'd0, op_count}, 32'd1);

      for (int i = 0; i < 5; i++) send1(8'h30 + 8'(i), 3'b110);
      repeat (4) @(posedge clk);
      #1;
      check("sat_count", {30'd0, op_count1}, 32'd3);
      send1(8'h01, 3'b101);
      clr_cnt1 = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("clr_priority", {30'd0, op_count1}, 32'd0);
      send1(8'h02, 3'b010);
      repeat (4) @(posedge clk);
      #1;
      check("count_after_clr", {30'd0, op_count1}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
